pe_array_seq_ctrl: RTL and testbench
====================================

// Module: pe_array_seq_ctrl
// PURPOSE
//  Sequencer for the 8x4 systolic PE array. Per output-channel group it fetches one weight column from the weight
//  buffer, pulses new_weight_val to latch it, streams slide-window beats from the SWU, and strobes result capture
//  as each beat leaves row 7. Groups are processed back-to-back. Sits between layer control, weight buffer, SWU
//  and the PE array.
// PARAMETERS
//  ROWS      8   PE rows (weights per column)
//  COLS      4   PE columns (slide lanes)
//  WB_AW     8   weight-buffer address width
//  LEN_W     10  beat-count width
//  PIPE_LAT  9   cycles from accepted slide beat to row-7 output valid
// PORTS
//  clk             in   1      clock, rising edge
//  rst_n           in   1      synchronous, active-low reset
//  cfg_start       in   1      start pulse; cfg_* sampled on this cycle
//  cfg_wbase       in   WB_AW  weight address of group 0
//  cfg_ngroups     in   4      number of weight groups
//  cfg_nbeats      in   LEN_W  slide beats per group
//  busy            out  1      high in any non-IDLE state except DONE
//  done            out  1      one-cycle completion pulse
//  wb_rd_en        out  1      weight buffer read strobe (fixed 1-cycle read latency)
//  wb_rd_addr      out  WB_AW  weight read address
//  new_weight_val  out  1      to PE array: latch w_00..w_70
//  swu_req         out  1      ready for a slide beat
//  swu_vld         in   1      SWU beat valid; beat accepted when swu_req & swu_vld
//  res_vld         out  1      PE outputs o_00..o_73 valid this cycle
//  res_group       out  4      group index of res_vld beat
//  res_idx         out  LEN_W  beat index within group of res_vld beat
// BEHAVIOUR
//  Reset: every output 0, state IDLE, tracker cleared, counters 0. Applies on any edge with rst_n=0, including
//   mid-operation; no partial completion and no done pulse.
//  States: IDLE -> WREQ -> WLOAD -> FEED -> DRAIN -> (WREQ | DONE) -> IDLE.
//   IDLE:  cfg_start latches config, g=0. If ngroups==0 or nbeats==0, go to DONE; else go to WREQ.
//   WREQ:  wb_rd_en=1 for 1 cycle, wb_rd_addr = (wbase + g) mod 2^WB_AW.
//   WLOAD: new_weight_val=1 for exactly 1 cycle (read data is present on this cycle).
//   FEED:  swu_req=1. Each accept increments beat counter b. After accept with b==nbeats-1, go to DRAIN.
//          The same cycle drops swu_req, so no extra beat is taken. swu_vld gaps stall FEED and are not errors.
//   DRAIN: wait until tracker is empty. Then, if g+1<ngroups, g++ and go to WREQ; else go to DONE.
//   DONE:  done=1, busy=0 for 1 cycle, then IDLE.
//  Tracker: PIPE_LAT-deep shift register of accept flags. res_vld = tail bit, so res_vld follows each accept by
//   exactly PIPE_LAT cycles and preserves gaps. res_idx counts res_vld within a group and clears when DRAIN exits.
//   res_group = g at emission.
//  new_weight_val never coincides with an accept or with a nonzero tracker bit. Weights are never swapped while
//   beats are in flight.
//  cfg_start while not IDLE is ignored; latched config is unaffected.
//  Latency, per group (swu_vld held high): 2 + nbeats + PIPE_LAT cycles. done follows the final res_vld by 1 cycle.
//  Counter widths hold no overflow: b < nbeats <= 2^LEN_W-1.
// STRUCTURE
//  pe_array_pkg: ROWS, COLS, weight/slide data width 7, PE output width 4 (signed), state encoding localparams.
//  Sub-module pe_pipe_tracker: PIPE_LAT-bit valid shift register with push, tail and empty outputs.
//  Top level holds the FSM, group/beat/result counters and address add.
// TESTING
//  Fixed parameters: PIPE_LAT=9. Cycle 0 = the start cycle.
//  1) start, wbase=8'h10, ngroups=1, nbeats=3, swu_vld=1:
//     wb_rd_en@1 addr=0x10; new_weight_val@2; accepts@3,4,5; res_vld@12,13,14 with idx 0,1,2; done@15.
//  2) wbase=8'hFF, ngroups=2, nbeats=2:
//     second wb_rd_addr=0x00 (wrap); res_group 0 then 1; new_weight_val only after group-0 tracker is empty.
//  3) nbeats=4, swu_vld pattern 1,0,0,1,1,1:
//     res_vld pattern identical, shifted by 9 cycles; res_idx 0..3; exactly 4 accepts.
//  4) ngroups=0 (then nbeats=0):
//     done on the cycle after start; wb_rd_en, new_weight_val, swu_req stay 0.
//  5) rst_n=0 for 1 cycle during FEED after 2 accepts:
//     all outputs 0 next cycle, no res_vld afterwards, no done; a fresh start then runs as scenario 1.
//  6) cfg_start re-pulsed with different cfg during FEED:
//     ignored; addresses and counts match the original config.

Source files
------------

// File: rtl/pe_array_pkg.sv
// Shared types and constants for the 8x4 systolic PE array sequencer.
// Includes array geometry, data widths and the sequencer state encoding.
package pe_array_pkg;

  localparam int ROWS     = 8;
  localparam int COLS     = 4;
  localparam int DATA_W   = 7;
  localparam int PE_OUT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WREQ  = 3'd1,
    ST_WLOAD = 3'd2,
    ST_FEED  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_t;

endpackage

// File: rtl/pe_pipe_tracker.sv
// Shift register of accepted-beat flags that mirrors the PE array pipeline depth.
// The tail bit marks the cycle a beat's results leave row 7.
module pe_pipe_tracker #(
  parameter int PIPE_LAT = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  output logic tail,
  output logic empty,
  output logic last
);

  logic [PIPE_LAT-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[PIPE_LAT-2:0], push};
  end

  assign tail  = sr[PIPE_LAT-1];
  assign empty = (sr == '0);
  // Only the tail (if anything) is still in flight, so the pipe is clear next cycle.
  assign last  = (sr[PIPE_LAT-2:0] == '0);

endmodule

// File: rtl/pe_array_seq_ctrl.sv
// Sequencer for the 8x4 PE array: per group it loads one weight column, streams
// slide beats from the SWU and strobes result capture as each beat leaves row 7.
module pe_array_seq_ctrl
  import pe_array_pkg::*;
#(
  parameter int WB_AW    = 8,
  parameter int LEN_W    = 10,
  parameter int PIPE_LAT = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [WB_AW-1:0] cfg_wbase,
  input  logic [3:0]       cfg_ngroups,
  input  logic [LEN_W-1:0] cfg_nbeats,
  output logic             busy,
  output logic             done,
  output logic             wb_rd_en,
  output logic [WB_AW-1:0] wb_rd_addr,
  output logic             new_weight_val,
  output logic             swu_req,
  input  logic             swu_vld,
  output logic             res_vld,
  output logic [3:0]       res_group,
  output logic [LEN_W-1:0] res_idx,
  output seq_state_t       state_dbg
);

  seq_state_t       state;
  logic [WB_AW-1:0] wbase;
  logic [3:0]       ngroups;
  logic [LEN_W-1:0] nbeats;
  logic [3:0]       g;
  logic [LEN_W-1:0] b;
  logic [4:0]       g_nxt;
  logic             accept;
  logic             trk_tail;
  logic             trk_empty;
  logic             trk_last;

  // SWU handshake: a beat transfers on any cycle where swu_req && swu_vld;
  // swu_req never depends on swu_vld, and a low swu_vld simply stalls the feed.
  assign accept    = swu_req & swu_vld;
  assign g_nxt     = {1'b0, g} + 5'd1;
  assign res_vld   = trk_tail;
  assign res_group = g;
  assign state_dbg = state;

  pe_pipe_tracker #(.PIPE_LAT(PIPE_LAT)) u_tracker (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .tail  (trk_tail),
    .empty (trk_empty),
    .last  (trk_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      wbase          <= '0;
      ngroups        <= '0;
      nbeats         <= '0;
      g              <= '0;
      b              <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      wb_rd_en       <= 1'b0;
      wb_rd_addr     <= '0;
      new_weight_val <= 1'b0;
      swu_req        <= 1'b0;
      res_idx        <= '0;
    end else begin
      wb_rd_en       <= 1'b0;
      new_weight_val <= 1'b0;
      done           <= 1'b0;
      if (res_vld) res_idx <= res_idx + LEN_W'(1);

      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            wbase   <= cfg_wbase;
            ngroups <= cfg_ngroups;
            nbeats  <= cfg_nbeats;
            g       <= '0;
            b       <= '0;
            if (cfg_ngroups == '0 || cfg_nbeats == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state      <= ST_WREQ;
              busy       <= 1'b1;
              wb_rd_en   <= 1'b1;
              wb_rd_addr <= cfg_wbase;
            end
          end
        end
        // Weights are only swapped into the array once no beat is in flight.
        ST_WREQ: begin
          if (trk_empty) begin
            state          <= ST_WLOAD;
            new_weight_val <= 1'b1;
          end
        end
        ST_WLOAD: begin
          state   <= ST_FEED;
          swu_req <= 1'b1;
        end
        ST_FEED: begin
          if (accept) begin
            if (b == nbeats - LEN_W'(1)) begin
              b       <= '0;
              swu_req <= 1'b0;
              state   <= ST_DRAIN;
            end else begin
              b <= b + LEN_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (trk_last) begin
            res_idx <= '0;
            if (g_nxt < {1'b0, ngroups}) begin
              g          <= g_nxt[3:0];
              state      <= ST_WREQ;
              wb_rd_en   <= 1'b1;
              wb_rd_addr <= wbase + WB_AW'(g_nxt);
            end else begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_seq_ctrl.sv
// Bench for pe_array_seq_ctrl: directed table, reset/re-start sequences and
// randomized runs checked cycle by cycle against an event-based timing model.
module tb_pe_array_seq_ctrl;
  import pe_array_pkg::*;

  localparam int WB_AW    = 8;
  localparam int LEN_W    = 10;
  localparam int PIPE_LAT = 9;
  localparam int MAXC     = 256;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_start = 1'b0;
  logic [WB_AW-1:0] cfg_wbase = '0;
  logic [3:0]       cfg_ngroups = '0;
  logic [LEN_W-1:0] cfg_nbeats = '0;
  logic             busy, done, wb_rd_en, new_weight_val, swu_req, res_vld;
  logic             swu_vld = 1'b0;
  logic [WB_AW-1:0] wb_rd_addr;
  logic [3:0]       res_group;
  logic [LEN_W-1:0] res_idx;
  seq_state_t       state_dbg;

  always #5 clk = ~clk;

  pe_array_seq_ctrl #(.WB_AW(WB_AW), .LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_wbase(cfg_wbase),
    .cfg_ngroups(cfg_ngroups), .cfg_nbeats(cfg_nbeats), .busy(busy), .done(done),
    .wb_rd_en(wb_rd_en), .wb_rd_addr(wb_rd_addr), .new_weight_val(new_weight_val),
    .swu_req(swu_req), .swu_vld(swu_vld), .res_vld(res_vld), .res_group(res_group),
    .res_idx(res_idx), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: per-cycle expected events, cycle 0 = start cycle.
  logic       vld_a  [MAXC];
  logic       e_rd   [MAXC];
  logic [7:0] e_addr [MAXC];
  logic       e_nwv  [MAXC];
  logic       e_req  [MAXC];
  logic       e_res  [MAXC];
  logic [3:0] e_grp  [MAXC];
  logic [9:0] e_idx  [MAXC];
  logic       e_busy [MAXC];
  int         e_done_c;

  task automatic fill_vld(input int mode, input logic [31:0] mask);
    for (int c = 0; c < MAXC; c++) begin
      if (mode == 1 && c < 32)       vld_a[c] = mask[c];
      else if (mode == 2 && c < 100) vld_a[c] = ($urandom_range(0, 9) < 6);
      else                           vld_a[c] = 1'b1;
    end
  endtask

  task automatic build_model(input logic [7:0] wb, input logic [3:0] ng, input logic [9:0] nb);
    int s, t, n;
    for (int c = 0; c < MAXC; c++) begin
      e_rd[c] = 0; e_addr[c] = 0; e_nwv[c] = 0; e_req[c] = 0;
      e_res[c] = 0; e_grp[c] = 0; e_idx[c] = 0; e_busy[c] = 0;
    end
    if (ng == 0 || nb == 0) begin
      e_done_c = 1;
    end else begin
      s = 1;
      for (int k = 0; k < int'(ng); k++) begin
        e_rd[s]   = 1;
        e_addr[s] = 8'((int'(wb) + k) % 256);
        e_nwv[s+1] = 1;
        t = s + 2;
        n = 0;
        while (n < int'(nb)) begin
          e_req[t] = 1;
          if (vld_a[t]) begin
            e_res[t+PIPE_LAT] = 1;
            e_grp[t+PIPE_LAT] = 4'(k);
            e_idx[t+PIPE_LAT] = 10'(n);
            n++;
          end
          t++;
        end
        s = (t - 1) + PIPE_LAT + 1;
      end
      e_done_c = s;
      for (int c = 1; c < e_done_c; c++) e_busy[c] = 1;
    end
  endtask

  task automatic run_case(input logic [7:0] wb, input logic [3:0] ng, input logic [9:0] nb,
                          input int repulse_c, input string tag,
                          output int done_seen, output int rd_cnt,
                          output logic [7:0] last_addr, output int acc_cnt);
    build_model(wb, ng, nb);
    done_seen = -1; rd_cnt = 0; last_addr = 0; acc_cnt = 0;
    for (int c = 0; c <= e_done_c + 2; c++) begin
      @(negedge clk);
      check($sformatf("%s c%0d wb_rd_en", tag, c), 32'(wb_rd_en), 32'(e_rd[c]));
      if (e_rd[c]) check($sformatf("%s c%0d wb_rd_addr", tag, c), 32'(wb_rd_addr), 32'(e_addr[c]));
      check($sformatf("%s c%0d new_weight_val", tag, c), 32'(new_weight_val), 32'(e_nwv[c]));
      check($sformatf("%s c%0d swu_req", tag, c), 32'(swu_req), 32'(e_req[c]));
      check($sformatf("%s c%0d res_vld", tag, c), 32'(res_vld), 32'(e_res[c]));
      if (e_res[c]) begin
        check($sformatf("%s c%0d res_group", tag, c), 32'(res_group), 32'(e_grp[c]));
        check($sformatf("%s c%0d res_idx", tag, c), 32'(res_idx), 32'(e_idx[c]));
      end
      check($sformatf("%s c%0d done", tag, c), 32'(done), 32'(c == e_done_c));
      check($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(e_busy[c]));
      if (wb_rd_en) begin rd_cnt++; last_addr = wb_rd_addr; end
      if (done && done_seen < 0) done_seen = c;
      cfg_start   = (c == 0) || (c == repulse_c);
      cfg_wbase   = (c == 0) ? wb : ~wb;
      cfg_ngroups = (c == 0) ? ng : ng + 4'd3;
      cfg_nbeats  = (c == 0) ? nb : nb + 10'd5;
      swu_vld     = vld_a[c];
      if (swu_req && swu_vld) acc_cnt++;
    end
    @(negedge clk);
    cfg_start = 0;
    swu_vld   = 0;
  endtask

  typedef struct {
    logic [7:0]  wbase;
    logic [3:0]  ngroups;
    logic [9:0]  nbeats;
    int          mode;
    logic [31:0] mask;
    int          exp_done;
    int          exp_rd;
    logic [7:0]  exp_last_addr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int ds, rc, ac, bad, pre_acc;
    logic [7:0] la;
    logic [3:0] rng;
    logic [9:0] rnb;
    logic [7:0] rwb;

    vecs[0] = '{8'h10, 4'd1, 10'd3, 0, 32'h0,          15, 1, 8'h10};
    vecs[1] = '{8'hFF, 4'd2, 10'd2, 0, 32'h0,          27, 2, 8'h00};
    vecs[2] = '{8'h20, 4'd1, 10'd4, 1, 32'hFFFF_FFCF,  18, 1, 8'h20};
    vecs[3] = '{8'h30, 4'd0, 10'd5, 0, 32'h0,           1, 0, 8'h00};
    vecs[4] = '{8'h30, 4'd3, 10'd0, 0, 32'h0,           1, 0, 8'h00};
    vecs[5] = '{8'hFE, 4'd3, 10'd1, 0, 32'h0,          37, 3, 8'h00};

    repeat (3) @(negedge clk);
    check("reset outputs", {busy, done, wb_rd_en, wb_rd_addr, new_weight_val, swu_req,
                            res_vld, res_group, res_idx}, 32'h0);
    check("reset state", 32'(state_dbg), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      fill_vld(vecs[i].mode, vecs[i].mask);
      run_case(vecs[i].wbase, vecs[i].ngroups, vecs[i].nbeats, -1, $sformatf("vec%0d", i),
               ds, rc, la, ac);
      check($sformatf("vec%0d done cycle", i), 32'(ds), 32'(vecs[i].exp_done));
      check($sformatf("vec%0d rd count", i), 32'(rc), 32'(vecs[i].exp_rd));
      if (vecs[i].exp_rd > 0) check($sformatf("vec%0d last addr", i), 32'(la), 32'(vecs[i].exp_last_addr));
      check($sformatf("vec%0d accepts", i), 32'(ac),
            32'((vecs[i].ngroups == 0) ? 0 : int'(vecs[i].ngroups) * int'(vecs[i].nbeats)));
    end

    // Reset during FEED after two accepted beats.
    pre_acc = 0;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      cfg_start = (c == 0); cfg_wbase = 8'h10; cfg_ngroups = 4'd1; cfg_nbeats = 10'd3;
      swu_vld = 1'b1;
      if (c < 5 && swu_req) pre_acc++;
      if (c == 5) rst_n = 1'b0;
    end
    @(negedge clk);
    check("pre-reset accepts", 32'(pre_acc), 32'd2);
    check("outputs after mid reset", {busy, done, wb_rd_en, wb_rd_addr, new_weight_val, swu_req,
                                      res_vld, res_group, res_idx}, 32'h0);
    rst_n = 1'b1; cfg_start = 1'b0; swu_vld = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_vld || done || busy) bad++;
    end
    check("quiet after mid reset", 32'(bad), 32'd0);
    fill_vld(0, 32'h0);
    run_case(8'h10, 4'd1, 10'd3, -1, "restart", ds, rc, la, ac);
    check("restart done cycle", 32'(ds), 32'd15);

    // Start re-pulsed with a different config during FEED.
    fill_vld(0, 32'h0);
    run_case(8'h40, 4'd2, 10'd2, 4, "repulse", ds, rc, la, ac);
    check("repulse done cycle", 32'(ds), 32'd27);
    check("repulse rd count", 32'(rc), 32'd2);
    check("repulse last addr", 32'(la), 32'h41);
    check("repulse accepts", 32'(ac), 32'd4);

    for (int r = 0; r < 10; r++) begin
      rng = 4'($urandom_range(0, 3));
      rnb = 10'($urandom_range(0, 6));
      rwb = 8'($urandom_range(0, 255));
      fill_vld(2, 32'h0);
      run_case(rwb, rng, rnb, -1, $sformatf("rand%0d", r), ds, rc, la, ac);
      check($sformatf("rand%0d done cycle", r), 32'(ds), 32'(e_done_c));
      check($sformatf("rand%0d rd count", r), 32'(rc), 32'((rnb == 0) ? 0 : int'(rng)));
      check($sformatf("rand%0d accepts", r), 32'(ac), 32'((rnb == 0) ? 0 : int'(rng) * int'(rnb)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
